// File: rtl/seletor_mapa_param.sv
// ---------------------------------------------------------------------------
// seletor_mapa_param
//
// Purpose:
//   Holds NUM_MAPAS preset ship maps of LINHAS x COLUNAS cells. The player
//   previews a map either by direct index (modo=0, sel) or by browsing with
//   the proximo/anterior buttons (modo=1). A confirm press (rising edge of
//   confirmar while enable=1) latches the preview as the game map, computes
//   its occupied-cell count and locks the selector until liberar is raised.
//
// Ports:
//   clk          system clock, all state on the rising edge
//   reset_n      synchronous reset, active low
//   enable       confirm qualifier
//   modo         0 = direct select via sel, 1 = browse via buttons
//   sel          direct map index
//   proximo      browse-forward button level
//   anterior     browse-back button level
//   confirmar    confirm button level
//   liberar      unlock request level
//   indice       current preview index (registered)
//   mapaTemp     preview map selected by indice (combinational)
//   mapa         confirmed game map (registered)
//   num_celulas  number of occupied cells in mapa (registered)
//   travado      1 while locked
//   confirmado   one-cycle pulse after a capture
// ---------------------------------------------------------------------------
module seletor_mapa_param #(
  parameter int LINHAS    = 5,
  parameter int COLUNAS   = 7,
  parameter int NUM_MAPAS = 4,
  parameter int SEL_W     = 2,
  parameter int CNT_W     = 6,
  // Map k at [k*LINHAS*COLUNAS +: LINHAS*COLUNAS], row r at [r*COLUNAS +: COLUNAS].
  // Each map below is written row 4 first, row 0 last.
  parameter logic [NUM_MAPAS*LINHAS*COLUNAS-1:0] MAPAS = {
    7'h07, 7'h22, 7'h38, 7'h21, 7'h07,   // map 3
    7'h70, 7'h20, 7'h20, 7'h42, 7'h77,   // map 2
    7'h77, 7'h42, 7'h20, 7'h20, 7'h70,   // map 1
    7'h43, 7'h71, 7'h45, 7'h0C, 7'h04    // map 0
  }
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       modo,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       proximo,
  input  logic                       anterior,
  input  logic                       confirmar,
  input  logic                       liberar,
  output logic [SEL_W-1:0]           indice,
  output logic [LINHAS*COLUNAS-1:0]  mapaTemp,
  output logic [LINHAS*COLUNAS-1:0]  mapa,
  output logic [CNT_W-1:0]           num_celulas,
  output logic                       travado,
  output logic                       confirmado
);

  localparam int CELULAS = LINHAS * COLUNAS;

  typedef enum logic {
    PREPARANDO = 1'b0,
    TRAVADO    = 1'b1
  } estado_t;

  estado_t              state_reg;
  logic [SEL_W-1:0]     indice_reg;
  logic [CELULAS-1:0]   mapa_reg;
  logic [CNT_W-1:0]     num_celulas_reg;
  logic                 travado_reg;
  logic                 confirmado_reg;
  logic                 conf_prev_reg;
  logic                 prox_prev_reg;
  logic                 ant_prev_reg;

  logic [CELULAS-1:0]   mapas [NUM_MAPAS];
  logic [CELULAS-1:0]   mapa_temp;
  logic [CNT_W-1:0]     num_celulas_next;
  logic [SEL_W-1:0]     indice_inc;
  logic [SEL_W-1:0]     indice_dec;
  logic                 sel_valido;
  logic                 conf_edge;
  logic                 prox_edge;
  logic                 ant_edge;

  // Unpack the flat preset vector into one entry per map.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_MAPAS; gi++) begin : g_mapas
      assign mapas[gi] = MAPAS[gi*CELULAS +: CELULAS];
    end
  endgenerate

  // Explicit compare-mux so an index beyond NUM_MAPAS-1 (possible when
  // NUM_MAPAS is not a power of two) yields zeros instead of an
  // out-of-range array access. indice never takes such a value in practice.
  always_comb begin
    mapa_temp = '0;
    for (int k = 0; k < NUM_MAPAS; k++) begin
      if (indice_reg == SEL_W'(k)) begin
        mapa_temp = mapas[k];
      end
    end
  end

  always_comb begin
    num_celulas_next = '0;
    for (int i = 0; i < CELULAS; i++) begin
      num_celulas_next = num_celulas_next + CNT_W'(mapa_temp[i]);
    end
  end

  assign conf_edge  = confirmar & ~conf_prev_reg;
  assign prox_edge  = proximo   & ~prox_prev_reg;
  assign ant_edge   = anterior  & ~ant_prev_reg;

  assign sel_valido = (32'(sel) < NUM_MAPAS);
  assign indice_inc = (indice_reg == SEL_W'(NUM_MAPAS - 1)) ? '0 : indice_reg + SEL_W'(1);
  assign indice_dec = (indice_reg == '0) ? SEL_W'(NUM_MAPAS - 1) : indice_reg - SEL_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= PREPARANDO;
      indice_reg      <= '0;
      mapa_reg        <= '0;
      num_celulas_reg <= '0;
      travado_reg     <= 1'b0;
      confirmado_reg  <= 1'b0;
      conf_prev_reg   <= 1'b0;
      prox_prev_reg   <= 1'b0;
      ant_prev_reg    <= 1'b0;
    end else begin
      // Edge flops sample in every state, so a button held through an
      // unlock or a disabled confirm never produces a late edge.
      conf_prev_reg  <= confirmar;
      prox_prev_reg  <= proximo;
      ant_prev_reg   <= anterior;
      confirmado_reg <= 1'b0;

      case (state_reg)
        PREPARANDO: begin
          if (conf_edge) begin
            // A confirm edge always blocks the index update; with enable=0
            // it is simply consumed.
            if (enable) begin
              mapa_reg        <= mapa_temp;
              num_celulas_reg <= num_celulas_next;
              confirmado_reg  <= 1'b1;
              travado_reg     <= 1'b1;
              state_reg       <= TRAVADO;
            end
          end else if (!modo) begin
            if (sel_valido) begin
              indice_reg <= sel;
            end
          end else if (prox_edge && !ant_edge) begin
            indice_reg <= indice_inc;
          end else if (ant_edge && !prox_edge) begin
            indice_reg <= indice_dec;
          end
        end

        TRAVADO: begin
          if (liberar) begin
            travado_reg <= 1'b0;
            state_reg   <= PREPARANDO;
          end
        end

        default: begin
          travado_reg <= 1'b0;
          state_reg   <= PREPARANDO;
        end
      endcase
    end
  end

  assign indice      = indice_reg;
  assign mapaTemp    = mapa_temp;
  assign mapa        = mapa_reg;
  assign num_celulas = num_celulas_reg;
  assign travado     = travado_reg;
  assign confirmado  = confirmado_reg;

endmodule

// File: tb/tb_seletor_mapa_param.sv
// ---------------------------------------------------------------------------
// tb_seletor_mapa_param
//
// Purpose:
//   Scoreboard bench for seletor_mapa_param. Two instances: the default
//   5x7 / 4-map configuration and a 4x8 / 3-map one. Stimulus pushes the
//   expected state into a snapshot queue and expected captures into a
//   per-instance capture queue; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_seletor_mapa_param;

  typedef struct {
    int          which;
    string       nome;
    logic [1:0]  idx;
    logic [63:0] mt;
    logic [63:0] mp;
    logic [5:0]  num;
    logic        trav;
    logic        conf;
  } snap_t;

  typedef struct {
    logic [63:0] mp;
    logic [5:0]  num;
  } cap_t;

  // Default maps, written row 4 first.
  localparam logic [63:0] M0 = 64'({7'h43, 7'h71, 7'h45, 7'h0C, 7'h04});
  localparam logic [63:0] M1 = 64'({7'h77, 7'h42, 7'h20, 7'h20, 7'h70});
  localparam logic [63:0] M2 = 64'({7'h70, 7'h20, 7'h20, 7'h42, 7'h77});
  localparam logic [63:0] M3 = 64'({7'h07, 7'h22, 7'h38, 7'h21, 7'h07});

  // Second configuration: 4 rows x 8 columns, 3 maps.
  localparam logic [31:0] N0 = 32'h0000_0001;
  localparam logic [31:0] N1 = 32'h0F0F_0F0F;
  localparam logic [31:0] N2 = 32'hFFFF_0000;
  localparam logic [95:0] MAPAS2 = {N2, N1, N0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1 signals
  logic        rst1_n, en1, modo1, prox1, ant1, conf1, lib1;
  logic [1:0]  sel1;
  logic [1:0]  d1_indice;
  logic [34:0] d1_mapaTemp, d1_mapa;
  logic [5:0]  d1_num;
  logic        d1_travado, d1_confirmado;

  // Instance 2 signals
  logic        rst2_n, en2, modo2, prox2, ant2, conf2, lib2;
  logic [1:0]  sel2;
  logic [1:0]  d2_indice;
  logic [31:0] d2_mapaTemp, d2_mapa;
  logic [5:0]  d2_num;
  logic        d2_travado, d2_confirmado;

  seletor_mapa_param dut (
    .clk(clk), .reset_n(rst1_n), .enable(en1), .modo(modo1), .sel(sel1),
    .proximo(prox1), .anterior(ant1), .confirmar(conf1), .liberar(lib1),
    .indice(d1_indice), .mapaTemp(d1_mapaTemp), .mapa(d1_mapa),
    .num_celulas(d1_num), .travado(d1_travado), .confirmado(d1_confirmado)
  );

  seletor_mapa_param #(
    .LINHAS(4), .COLUNAS(8), .NUM_MAPAS(3), .SEL_W(2), .CNT_W(6), .MAPAS(MAPAS2)
  ) dut2 (
    .clk(clk), .reset_n(rst2_n), .enable(en2), .modo(modo2), .sel(sel2),
    .proximo(prox2), .anterior(ant2), .confirmar(conf2), .liberar(lib2),
    .indice(d2_indice), .mapaTemp(d2_mapaTemp), .mapa(d2_mapa),
    .num_celulas(d2_num), .travado(d2_travado), .confirmado(d2_confirmado)
  );

  snap_t snap_q[$];
  cap_t  cap1_q[$];
  cap_t  cap2_q[$];
  int    checks = 0;
  int    errors = 0;

  logic [63:0] mtab1 [4];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input int which, input string nome, input logic [1:0] idx,
                     input logic [63:0] mt, input logic [63:0] mp,
                     input logic [5:0] num, input logic trav, input logic conf);
    snap_t s;
    s.which = which; s.nome = nome; s.idx = idx; s.mt = mt; s.mp = mp;
    s.num = num; s.trav = trav; s.conf = conf;
    snap_q.push_back(s);
  endtask

  task automatic exp_cap(input int which, input logic [63:0] mp, input logic [5:0] num);
    cap_t c;
    c.mp = mp; c.num = num;
    if (which == 1) cap1_q.push_back(c);
    else            cap2_q.push_back(c);
  endtask

  // Monitor: compares queued snapshots and every confirmado pulse.
  snap_t       e;
  cap_t        c;
  logic [1:0]  a_idx;
  logic [63:0] a_mt, a_mp;
  logic [5:0]  a_num;
  logic        a_trav, a_conf;

  always @(negedge clk) begin
    if (snap_q.size() > 0) begin
      e = snap_q.pop_front();
      if (e.which == 1) begin
        a_idx = d1_indice; a_mt = 64'(d1_mapaTemp); a_mp = 64'(d1_mapa);
        a_num = d1_num; a_trav = d1_travado; a_conf = d1_confirmado;
      end else begin
        a_idx = d2_indice; a_mt = 64'(d2_mapaTemp); a_mp = 64'(d2_mapa);
        a_num = d2_num; a_trav = d2_travado; a_conf = d2_confirmado;
      end
      checks++;
      if (a_idx !== e.idx || a_mt !== e.mt || a_mp !== e.mp || a_num !== e.num ||
          a_trav !== e.trav || a_conf !== e.conf) begin
        errors++;
        $display("FAIL %s: got idx=%0d mapaTemp=%h mapa=%h num=%0d trav=%b conf=%b, want idx=%0d mapaTemp=%h mapa=%h num=%0d trav=%b conf=%b",
                 e.nome, a_idx, a_mt, a_mp, a_num, a_trav, a_conf,
                 e.idx, e.mt, e.mp, e.num, e.trav, e.conf);
      end else begin
        $display("ok   %s idx=%0d mapa=%h num=%0d trav=%b conf=%b",
                 e.nome, a_idx, a_mp, a_num, a_trav, a_conf);
      end
    end

    if (d1_confirmado === 1'b1) begin
      checks++;
      if (cap1_q.size() == 0) begin
        errors++;
        $display("FAIL cap1_spurious: got confirmado=1 mapa=%h, want no capture", d1_mapa);
      end else begin
        c = cap1_q.pop_front();
        if (64'(d1_mapa) !== c.mp || d1_num !== c.num || d1_travado !== 1'b1) begin
          errors++;
          $display("FAIL cap1: got mapa=%h num=%0d trav=%b, want mapa=%h num=%0d trav=1",
                   d1_mapa, d1_num, d1_travado, c.mp, c.num);
        end else begin
          $display("ok   cap1 mapa=%h num=%0d", d1_mapa, d1_num);
        end
      end
    end

    if (d2_confirmado === 1'b1) begin
      checks++;
      if (cap2_q.size() == 0) begin
        errors++;
        $display("FAIL cap2_spurious: got confirmado=1 mapa=%h, want no capture", d2_mapa);
      end else begin
        c = cap2_q.pop_front();
        if (64'(d2_mapa) !== c.mp || d2_num !== c.num || d2_travado !== 1'b1) begin
          errors++;
          $display("FAIL cap2: got mapa=%h num=%0d trav=%b, want mapa=%h num=%0d trav=1",
                   d2_mapa, d2_num, d2_travado, c.mp, c.num);
        end else begin
          $display("ok   cap2 mapa=%h num=%0d", d2_mapa, d2_num);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    mtab1[0] = M0; mtab1[1] = M1; mtab1[2] = M2; mtab1[3] = M3;
    rst1_n = 1'b0; en1 = 1'b0; modo1 = 1'b0; sel1 = 2'd0;
    prox1 = 1'b0; ant1 = 1'b0; conf1 = 1'b0; lib1 = 1'b0;
    rst2_n = 1'b0; en2 = 1'b0; modo2 = 1'b0; sel2 = 2'd0;
    prox2 = 1'b0; ant2 = 1'b0; conf2 = 1'b0; lib2 = 1'b0;

    // Reset
    tick(); tick();
    chk(1, "reset", 2'd0, M0, 64'd0, 6'd0, 1'b0, 1'b0);
    rst1_n = 1'b1;

    // Direct select
    modo1 = 1'b0; sel1 = 2'd2; tick();
    chk(1, "sel2", 2'd2, M2, 64'd0, 6'd0, 1'b0, 1'b0);
    sel1 = 2'd0; tick();
    chk(1, "sel0", 2'd0, M0, 64'd0, 6'd0, 1'b0, 1'b0);

    // Browse forward 5 times: 1,2,3,0,1
    modo1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      prox1 = 1'b1; tick();
      chk(1, "prox", 2'((i + 1) % 4), mtab1[(i + 1) % 4], 64'd0, 6'd0, 1'b0, 1'b0);
      prox1 = 1'b0; tick();
    end
    ant1 = 1'b1; tick();
    chk(1, "ant_1to0", 2'd0, M0, 64'd0, 6'd0, 1'b0, 1'b0);
    ant1 = 1'b0; tick();
    ant1 = 1'b1; tick();
    chk(1, "ant_wrap", 2'd3, M3, 64'd0, 6'd0, 1'b0, 1'b0);
    ant1 = 1'b0; tick();
    prox1 = 1'b1; ant1 = 1'b1; tick();
    chk(1, "both_hold", 2'd3, M3, 64'd0, 6'd0, 1'b0, 1'b0);
    prox1 = 1'b0; ant1 = 1'b0; tick();
    prox1 = 1'b1; tick();
    chk(1, "prox_wrap", 2'd0, M0, 64'd0, 6'd0, 1'b0, 1'b0);
    tick();
    chk(1, "prox_held", 2'd0, M0, 64'd0, 6'd0, 1'b0, 1'b0);
    prox1 = 1'b0; tick();
    ant1 = 1'b1; tick();
    chk(1, "ant_to3", 2'd3, M3, 64'd0, 6'd0, 1'b0, 1'b0);
    ant1 = 1'b0; tick();

    // Capture map 3, confirmar held 4 cycles
    en1 = 1'b1; conf1 = 1'b1;
    exp_cap(1, M3, 6'd13);
    tick();
    chk(1, "capture", 2'd3, M3, M3, 6'd13, 1'b1, 1'b1);
    tick();
    chk(1, "pulse_end", 2'd3, M3, M3, 6'd13, 1'b1, 1'b0);
    tick(); tick();
    conf1 = 1'b0; tick();
    prox1 = 1'b1; tick();
    chk(1, "locked_prox", 2'd3, M3, M3, 6'd13, 1'b1, 1'b0);
    prox1 = 1'b0; modo1 = 1'b0; sel1 = 2'd1; tick();
    chk(1, "locked_sel", 2'd3, M3, M3, 6'd13, 1'b1, 1'b0);

    // Locked: re-confirm ignored, liberar beats confirm edge
    conf1 = 1'b1; tick();
    chk(1, "reconfirm", 2'd3, M3, M3, 6'd13, 1'b1, 1'b0);
    conf1 = 1'b0; tick();
    lib1 = 1'b1; conf1 = 1'b1; tick();
    chk(1, "liberar", 2'd3, M3, M3, 6'd13, 1'b0, 1'b0);
    lib1 = 1'b0; conf1 = 1'b0; tick();
    chk(1, "unlocked", 2'd1, M1, M3, 6'd13, 1'b0, 1'b0);

    // Confirm while disabled is consumed
    en1 = 1'b0; conf1 = 1'b1; tick();
    chk(1, "disabled", 2'd1, M1, M3, 6'd13, 1'b0, 1'b0);
    en1 = 1'b1; tick();
    chk(1, "enable_held", 2'd1, M1, M3, 6'd13, 1'b0, 1'b0);
    conf1 = 1'b0; tick();
    conf1 = 1'b1;
    exp_cap(1, M1, 6'd13);
    tick();
    chk(1, "recapture", 2'd1, M1, M1, 6'd13, 1'b1, 1'b1);
    conf1 = 1'b0; tick();

    // Reset while locked
    rst1_n = 1'b0; tick();
    chk(1, "reset_locked", 2'd0, M0, 64'd0, 6'd0, 1'b0, 1'b0);
    rst1_n = 1'b1; lib1 = 1'b1; tick();
    chk(1, "liberar_prep", 2'd1, M1, 64'd0, 6'd0, 1'b0, 1'b0);
    lib1 = 1'b0; tick();

    // Second configuration: 3 maps of 4x8
    rst2_n = 1'b1; modo2 = 1'b0; sel2 = 2'd2; tick();
    chk(2, "d2_sel2", 2'd2, 64'(N2), 64'd0, 6'd0, 1'b0, 1'b0);
    sel2 = 2'd3; tick();
    chk(2, "d2_sel3_hold", 2'd2, 64'(N2), 64'd0, 6'd0, 1'b0, 1'b0);
    modo2 = 1'b1; prox2 = 1'b1; tick();
    chk(2, "d2_wrap", 2'd0, 64'(N0), 64'd0, 6'd0, 1'b0, 1'b0);
    prox2 = 1'b0; tick();
    ant2 = 1'b1; tick();
    chk(2, "d2_ant_wrap", 2'd2, 64'(N2), 64'd0, 6'd0, 1'b0, 1'b0);
    ant2 = 1'b0; tick();
    prox2 = 1'b1; tick();
    chk(2, "d2_to0", 2'd0, 64'(N0), 64'd0, 6'd0, 1'b0, 1'b0);
    prox2 = 1'b0; tick();
    prox2 = 1'b1; tick();
    chk(2, "d2_to1", 2'd1, 64'(N1), 64'd0, 6'd0, 1'b0, 1'b0);
    prox2 = 1'b0; tick();
    en2 = 1'b1; conf2 = 1'b1;
    exp_cap(2, 64'(N1), 6'd16);
    tick();
    chk(2, "d2_capture", 2'd1, 64'(N1), 64'(N1), 6'd16, 1'b1, 1'b1);
    conf2 = 1'b0; tick();
    rst2_n = 1'b0; tick();
    chk(2, "d2_reset_locked", 2'd0, 64'(N0), 64'd0, 6'd0, 1'b0, 1'b0);
    rst2_n = 1'b1; tick(); tick();

    // Every expected capture must have been seen
    checks++;
    if (cap1_q.size() != 0 || cap2_q.size() != 0 || snap_q.size() != 0) begin
      errors++;
      $display("FAIL pending: got cap1=%0d cap2=%0d snap=%0d left, want 0 0 0",
               cap1_q.size(), cap2_q.size(), snap_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seletor_mapa_param.md
Name: seletor_mapa_param

Overview:
Parametrised, clocked successor to the fixed 5x7, four-map selector used in game preparation. It holds NUM_MAPAS preset ship maps of LINHAS x COLUNAS cells and lets the player preview a map, either by direct index or by browsing with next/previous buttons. On a confirmed press it latches the preview as the game map, locks until released, and reports the number of occupied cells so game logic can detect end-of-game.

Parameters:
LINHAS, 5, map rows.
COLUNAS, 7, cells per row.
NUM_MAPAS, 4, number of preset maps (>=2).
SEL_W, 2, index width = clog2(NUM_MAPAS).
CNT_W, 6, cell-count width = clog2(LINHAS*COLUNAS+1).
MAPAS, 4 maps x 35 bits, preset contents. Map k occupies bits [k*LINHAS*COLUNAS +: LINHAS*COLUNAS]; row r occupies [r*COLUNAS +: COLUNAS] within its map. Defaults, rows 0..4: map0 = 0x04,0x0C,0x45,0x71,0x43; map1 = 0x70,0x20,0x20,0x42,0x77; map2 = 0x77,0x42,0x20,0x20,0x70; map3 = 0x07,0x21,0x38,0x22,0x07.

Ports:
clk  in  1  system clock, all state on rising edge.
reset_n  in  1  synchronous reset, active low.
enable  in  1  confirm qualifier; confirm edges are ignored while 0.
modo  in  1  0 = direct select via sel; 1 = browse via proximo/anterior.
sel  in  SEL_W  direct map index (modo=0).
proximo  in  1  browse-forward button level.
anterior  in  1  browse-back button level.
confirmar  in  1  confirm button level.
liberar  in  1  unlock request level.
indice  out  SEL_W  current preview index (registered).
mapaTemp  out  LINHAS*COLUNAS  preview map = MAPAS slice at indice (combinational from indice).
mapa  out  LINHAS*COLUNAS  confirmed game map (registered).
num_celulas  out  CNT_W  popcount of mapa (registered).
travado  out  1  1 while in TRAVADO.
confirmado  out  1  one-cycle pulse on capture.

Behaviour:
- Reset (reset_n=0 at clk edge): indice=0, mapa=0, num_celulas=0, travado=0, confirmado=0, all edge-detect flops=0, state=PREPARANDO. Reset applies in any state, including mid-TRAVADO.
- Edge detect: confirmar, proximo and anterior are each sampled into a previous-value flop. An edge is current=1 & previous=0. A held level gives exactly one edge.
- FSM has two states, PREPARANDO and TRAVADO.
- PREPARANDO, index update when there is no confirm edge:
  - modo=0: indice <= sel if sel < NUM_MAPAS, otherwise hold.
  - modo=1: proximo edge increments, wrapping NUM_MAPAS-1 -> 0. anterior edge decrements, wrapping 0 -> NUM_MAPAS-1. Both edges in the same cycle: hold.
- PREPARANDO, capture (confirm edge & enable=1):
  - mapa <= mapaTemp for the pre-edge indice.
  - num_celulas <= popcount of that map; mapa and num_celulas update in the same cycle.
  - confirmado=1 for exactly that next cycle.
  - state -> TRAVADO; the index update is suppressed that cycle.
- Confirm edge with enable=0: no capture. The edge is consumed; holding confirmar while enable later rises does not capture.
- TRAVADO:
  - travado=1; indice frozen; sel, proximo, anterior and confirm edges are ignored.
  - liberar=1 -> PREPARANDO next cycle; mapa and num_celulas retained.
  - liberar together with a confirm edge: liberar wins, no capture.
- liberar in PREPARANDO: no effect.
- Edge flops keep sampling in all states, so a button held across unlock does not produce a spurious edge.
- Latency: button edge to indice is 1 cycle after the sampled level; indice to mapaTemp is combinational; capture to mapa/confirmado/travado is 1 cycle.

Test Plan:
1. Reset, then modo=0, sel=2, 1 cycle -> indice=2, mapaTemp row0=0x77 and row4=0x70; mapa=0, travado=0.
2. modo=1 from indice=0: proximo pulsed 5 times -> indice sequence 1,2,3,0,1. anterior at indice 0 -> 3. Both pressed together -> unchanged.
3. indice=3, enable=1, confirmar rises and is held 4 cycles -> one confirmado pulse; mapa rows = 0x07,0x21,0x38,0x22,0x07; num_celulas=13; travado=1. Further proximo/sel changes leave indice=3.
4. In TRAVADO: confirmar re-pressed -> no change. liberar=1 with a simultaneous confirm edge -> travado=0, mapa unchanged, confirmado stays 0.
5. enable=0, confirm edge -> no capture. Raise enable while confirmar is still held -> still no capture. Release and re-press -> capture.
6. Reset asserted in TRAVADO with mapa=map1 -> next cycle mapa=0, num_celulas=0, indice=0, travado=0. Repeat with LINHAS=4, COLUNAS=8, NUM_MAPAS=3 (SEL_W=2, CNT_W=6): sel=3 is held, and browsing wraps 2->0.
